// File: rtl/ppm_pulser.sv
// Pulse-position modulator: one symbol per frame of 2**SYM_BITS slots.
// A single pulse of PULSE_CYCLES is placed at the start of the slot whose
// index equals the captured symbol, followed by GUARD_CYCLES dead cycles.
//
// Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
// sym_ready is high only while idle, and sym_valid/sym_data are don't-care
// whenever sym_ready is low. Every output is decoded from registered state,
// so no input reaches an output combinationally.
module ppm_pulser #(
  parameter int SYM_BITS     = 2,
  parameter int SLOT_CYCLES  = 16,
  parameter int PULSE_CYCLES = 10,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sym_valid,
  input  logic [SYM_BITS-1:0] sym_data,
  output logic                sym_ready,
  input  logic                abort,
  output logic                pulse,
  output logic                busy,
  output logic                frame_done,
  output logic [1:0]          state_dbg
);

  // One counter serves both slot timing and guard timing, so it must hold
  // the larger of the two limits.
  localparam int CNT_MAX = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]       SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0]       PULSE_LIM  = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0]       GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
  localparam logic [SYM_BITS-1:0] SLOT_MAX   = {SYM_BITS{1'b1}};
  localparam logic [SYM_BITS-1:0] SLOT_ONE   = SYM_BITS'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  // Reject parameter sets that would break the slot/pulse arithmetic.
  if (SYM_BITS < 1) begin : g_bad_sym_bits
    $error("ppm_pulser: SYM_BITS must be >= 1");
  end
  if (SLOT_CYCLES < 1) begin : g_bad_slot_cycles
    $error("ppm_pulser: SLOT_CYCLES must be >= 1");
  end
  if ((PULSE_CYCLES < 1) || (PULSE_CYCLES > SLOT_CYCLES)) begin : g_bad_pulse_cycles
    $error("ppm_pulser: PULSE_CYCLES must be in 1..SLOT_CYCLES");
  end
  if ((GUARD_CYCLES < 0) || (GUARD_CYCLES > 255)) begin : g_bad_guard_cycles
    $error("ppm_pulser: GUARD_CYCLES must be in 0..255");
  end

  logic [1:0]          state_q, state_d;
  logic [SYM_BITS-1:0] sym_q, sym_d;
  logic [SYM_BITS-1:0] slot_q, slot_d;
  logic [CW-1:0]       cyc_q, cyc_d;

  // Next-state logic: accept in idle, walk slots in frame, count out the guard.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    slot_d  = slot_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        // abort is meaningless here; an accept proceeds regardless of it
        if (sym_valid && sym_ready) begin
          sym_d   = sym_data;
          slot_d  = '0;
          cyc_d   = '0;
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (abort) begin
          slot_d  = '0;
          cyc_d   = '0;
          state_d = S_IDLE;
        end else if (cyc_q == SLOT_LAST) begin
          cyc_d = '0;
          if (slot_q == SLOT_MAX) begin
            slot_d  = '0;
            state_d = (GUARD_CYCLES > 0) ? S_GUARD : S_IDLE;
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end else begin
          cyc_d = cyc_q + CNT_ONE;
        end
      end
      S_GUARD: begin
        if (abort || (cyc_q == GUARD_LAST)) begin
          slot_d  = '0;
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CNT_ONE;
        end
      end
      default: begin
        slot_d  = '0;
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sym_q   <= '0;
      slot_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      slot_q  <= slot_d;
      cyc_q   <= cyc_d;
    end
  end

  // Output decode from registered state only; reset drops pulse instantly.
  assign sym_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign pulse      = (state_q == S_FRAME) && (slot_q == sym_q) && (cyc_q < PULSE_LIM);
  assign frame_done = (state_q == S_FRAME) && (slot_q == SLOT_MAX) && (cyc_q == SLOT_LAST);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ppm_pulser.sv
// Bench for ppm_pulser: per-cycle expected output vectors are generated from
// the frame timing formulas when a symbol is offered, then popped and
// compared one per clock.
module tb_ppm_pulser;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       abort;
  logic       sel;

  logic       sym_ready_a, pulse_a, busy_a, frame_done_a;
  logic [1:0] state_dbg_a;
  logic       sym_ready_b, pulse_b, busy_b, frame_done_b;
  logic [1:0] state_dbg_b;

  logic       obs_ready, obs_busy, obs_pulse, obs_done;

  int checks   = 0;
  int failures = 0;

  // expected {sym_ready, busy, pulse, frame_done} per cycle
  logic [3:0] exp_q[$];

  ppm_pulser #(
    .SYM_BITS(2), .SLOT_CYCLES(16), .PULSE_CYCLES(10), .GUARD_CYCLES(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready_a), .abort(abort), .pulse(pulse_a), .busy(busy_a),
    .frame_done(frame_done_a), .state_dbg(state_dbg_a)
  );

  ppm_pulser #(
    .SYM_BITS(2), .SLOT_CYCLES(4), .PULSE_CYCLES(4), .GUARD_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready_b), .abort(abort), .pulse(pulse_b), .busy(busy_b),
    .frame_done(frame_done_b), .state_dbg(state_dbg_b)
  );

  assign obs_ready = sel ? sym_ready_b  : sym_ready_a;
  assign obs_busy  = sel ? busy_b       : busy_a;
  assign obs_pulse = sel ? pulse_b      : pulse_a;
  assign obs_done  = sel ? frame_done_b : frame_done_a;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Push the expected trace of one frame: cycle k=1 is the first cycle after
  // the accepting edge. trunc>0 keeps only cycles 1..trunc (abort/reset).
  task automatic expect_frame(input int s, input int sc, input int pc, input int gc,
                              input int trunc, input bit add_idle);
    int total;
    int n;
    logic p;
    logic fd;
    total = 4 * sc + gc;
    n = (trunc > 0) ? trunc : total;
    for (int k = 1; k <= n; k++) begin
      p  = (k <= 4 * sc) && (k >= s * sc + 1) && (k <= s * sc + pc);
      fd = (k == 4 * sc);
      exp_q.push_back({1'b0, 1'b1, p, fd});
    end
    if (add_idle) exp_q.push_back(4'b1000);
  endtask

  // Clock the DUT until the scoreboard is empty, comparing every cycle.
  task automatic drain(input string name, input int drop_at, input int chg_at,
                       input logic [1:0] chg_val, input int abort_at, input bit toggle);
    int k;
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      k++;
      if (k == drop_at) sym_valid = 1'b0;
      if (k == chg_at) sym_data = chg_val;
      abort = (k == abort_at);
      obs_v = {obs_ready, obs_busy, obs_pulse, obs_done};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL %s cycle %0d: got rdy/busy/pulse/done=%b expected %b",
                 name, k, obs_v, exp_v);
      end
      if (toggle) begin
        sym_data  = 2'($urandom_range(0, 3));
        sym_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (obs_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s sym_ready: got %b expected 1", name, obs_ready);
    end
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: got %b expected 0", name, obs_busy);
    end
    checks++;
    if (obs_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: got %b expected 0", name, obs_pulse);
    end
    checks++;
    if (obs_done !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_done: got %b expected 0", name, obs_done);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    release_reset();
  endtask

  // symbol 2 offered right after reset release
  task automatic test_single();
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    expect_frame(2, 16, 10, 4, 0, 1'b1);
    drain("single_sym2", 1, 0, 2'd0, 0, 1'b0);
  endtask

  // valid held high: symbol 0 then 3, second accepted at cycle 69
  task automatic test_back_to_back();
    sym_valid = 1'b1;
    sym_data  = 2'd0;
    expect_frame(0, 16, 10, 4, 0, 1'b1);
    expect_frame(3, 16, 10, 4, 0, 1'b1);
    drain("back_to_back", 70, 2, 2'd3, 0, 1'b0);
  endtask

  // inputs toggling while busy must not move the pulse
  task automatic test_toggle();
    sym_valid = 1'b1;
    sym_data  = 2'd1;
    expect_frame(1, 16, 10, 4, 0, 1'b1);
    drain("toggle_sym1", 1, 0, 2'd0, 0, 1'b1);
    sym_valid = 1'b0;
  endtask

  task automatic test_abort();
    // abort inside the pulse of slot 1
    sym_valid = 1'b1;
    sym_data  = 2'd1;
    expect_frame(1, 16, 10, 4, 20, 1'b1);
    drain("abort_c20", 1, 0, 2'd0, 20, 1'b0);
    // abort in idle on the accepting edge is ignored
    sym_valid = 1'b1;
    sym_data  = 2'd3;
    abort     = 1'b1;
    expect_frame(3, 16, 10, 4, 0, 1'b1);
    drain("accept_with_idle_abort", 1, 0, 2'd0, 0, 1'b0);
    // abort on the last frame cycle: frame_done still shows, no guard
    sym_valid = 1'b1;
    sym_data  = 2'd0;
    expect_frame(0, 16, 10, 4, 64, 1'b1);
    drain("abort_last_cycle", 1, 0, 2'd0, 64, 1'b0);
    // abort during guard
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    expect_frame(2, 16, 10, 4, 66, 1'b1);
    drain("abort_guard", 1, 0, 2'd0, 66, 1'b0);
  endtask

  // reset asserted mid-pulse, between clock edges
  task automatic test_reset_mid();
    sym_valid = 1'b1;
    sym_data  = 2'd0;
    expect_frame(0, 16, 10, 4, 5, 1'b0);
    drain("pre_reset_sym0", 1, 0, 2'd0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    release_reset();
    sym_valid = 1'b1;
    sym_data  = 2'd1;
    expect_frame(1, 16, 10, 4, 0, 1'b1);
    drain("after_reset_sym1", 1, 0, 2'd0, 0, 1'b0);
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 3; i++) begin
      s = $urandom_range(0, 3);
      sym_valid = 1'b1;
      sym_data  = 2'(s);
      expect_frame(s, 16, 10, 4, 0, 1'b1);
      drain("random_sym", 1, 0, 2'd0, 0, 1'b0);
    end
  endtask

  // short slots, full-width pulse, no guard
  task automatic test_small();
    sel   = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("small_reset");
    release_reset();
    sym_valid = 1'b1;
    sym_data  = 2'd3;
    expect_frame(3, 4, 4, 0, 0, 1'b1);
    drain("small_sym3", 1, 0, 2'd0, 0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b1;
    sym_valid = 1'b0;
    sym_data  = 2'd0;
    abort     = 1'b0;
    sel       = 1'b0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_toggle();
    test_abort();
    test_reset_mid();
    test_random();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppm_pulser.md
PPM_PULSER -- requirements
Module: ppm_pulser

Interface
REQ-001 SHALL have parameter SYM_BITS, default 2, bits per PPM symbol; frame = 2**SYM_BITS slots.
REQ-002 SHALL have parameter SLOT_CYCLES, default 16, clock cycles per slot.
REQ-003 SHALL have parameter PULSE_CYCLES, default 10, pulse width in cycles, legal range 1..SLOT_CYCLES.
REQ-004 SHALL have parameter GUARD_CYCLES, default 4, dead cycles after each frame, legal range 0..255.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sym_valid  input  1  symbol offered.
REQ-008 SHALL have port sym_data  input  SYM_BITS  symbol value = pulse slot index.
REQ-009 SHALL have port sym_ready  output  1  block can accept a symbol.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the frame in progress.
REQ-011 SHALL have port pulse  output  1  modulated optical drive.
REQ-012 SHALL have port busy  output  1  frame or guard in progress.
REQ-013 SHALL have port frame_done  output  1  one-cycle strobe on normal frame completion.

Function
REQ-014 SHALL implement states IDLE, FRAME, GUARD.
REQ-015 SHALL assert sym_ready only in IDLE; sym_ready SHALL be 0 in FRAME and GUARD.
REQ-016 SHALL accept a symbol on a rising edge where sym_valid && sym_ready, capture sym_data into sym_reg, zero slot_cnt and cyc_cnt, and enter FRAME.
REQ-017 SHALL ignore sym_valid and sym_data while not in IDLE; sym_reg SHALL be unchanged.
REQ-018 SHALL increment cyc_cnt each FRAME cycle, wrap from SLOT_CYCLES-1 to 0, and increment slot_cnt on each wrap.
REQ-019 SHALL drive pulse = (state==FRAME) && (slot_cnt==sym_reg) && (cyc_cnt<PULSE_CYCLES), decoded from registered state only, with no combinational path from any input.
REQ-020 SHALL number cycles from 1 = first cycle after the accepting edge; the pulse is then high for cycles s*SLOT_CYCLES+1 .. s*SLOT_CYCLES+PULSE_CYCLES, with exactly one pulse per frame.
REQ-021 SHALL assert frame_done high for exactly one cycle, during the last FRAME cycle (slot_cnt=2**SYM_BITS-1, cyc_cnt=SLOT_CYCLES-1).
REQ-022 SHALL leave FRAME after its last cycle and enter GUARD if GUARD_CYCLES>0, else IDLE.
REQ-023 SHALL remain in GUARD for exactly GUARD_CYCLES cycles (counted by cyc_cnt) with pulse=0, then enter IDLE.
REQ-024 SHALL make the minimum accept-to-accept spacing 2**SYM_BITS*SLOT_CYCLES + GUARD_CYCLES + 1 cycles.
REQ-025 SHALL assert busy in FRAME and GUARD and deassert it in IDLE.
REQ-026 SHALL, when abort=1 on an edge in FRAME or GUARD, enter IDLE on that edge, clear counters, and never emit frame_done for the aborted frame.
REQ-027 SHALL, if abort and the last FRAME cycle coincide, give abort priority: frame_done still shows for that cycle (it is registered-state decoded), and the next state is IDLE with no GUARD.
REQ-028 SHALL ignore abort in IDLE; an accept on the same edge as abort in IDLE SHALL proceed normally.
REQ-029 SHALL size counters to $clog2(max(SLOT_CYCLES,GUARD_CYCLES)+1) and SYM_BITS bits, with no overflow at any legal parameter value.
REQ-030 SHALL raise an elaboration-time error for an illegal PULSE_CYCLES, SLOT_CYCLES<1 or SYM_BITS<1.

Reset
REQ-031 SHALL, on rst_n=0, immediately set state IDLE, counters and sym_reg 0, pulse 0, busy 0, frame_done 0, and sym_ready 1, regardless of clk.
REQ-032 SHALL reach the same state on reset asserted mid-FRAME or mid-GUARD, with pulse dropping without waiting for a clock edge.
REQ-033 SHALL accept a symbol on the first rising edge after rst_n deasserts.

Verification (defaults SYM_BITS=2, SLOT_CYCLES=16, PULSE_CYCLES=10, GUARD_CYCLES=4)
REQ-034 SHALL cover: symbol 2 accepted -> pulse high cycles 33..42 only; frame_done at cycle 64; busy for cycles 1..68; sym_ready=1 at cycle 69.
REQ-035 SHALL cover: sym_valid held high with symbols 0 then 3 -> second accept 69 cycles after the first; pulses at cycles 1..10 and 70+48..70+57.
REQ-036 SHALL cover: sym_data toggling while busy -> pulse position follows the captured value only.
REQ-037 SHALL cover: symbol 1, abort at cycle 20 -> pulse low from cycle 21, no frame_done, sym_ready=1 next cycle, and a fresh accept works.
REQ-038 SHALL cover: rst_n pulsed low at cycle 5 of symbol 0 -> pulse=0 immediately, all outputs at reset values.
REQ-039 SHALL cover: SLOT_CYCLES=PULSE_CYCLES=4, GUARD_CYCLES=0, symbol 3 -> pulse at cycles 13..16, frame_done at cycle 16, sym_ready at cycle 17.
